// File: rtl/sound_mixer_scheduler.sv
// Sample-rate mixer: snapshots four signed sources and gains on each tick,
// then runs a time-shared multiply-accumulate over the channels and clips the sum.
// Ports: clk, reset_n (async, active-low), enable, src0..src3 (signed 16),
//        vol (4x4-bit gains), sound_out (signed 16), sample_tick, sample_valid.
module sound_mixer_scheduler #(
    parameter int unsigned DIV = 896
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] src0,
    input  logic [15:0] src1,
    input  logic [15:0] src2,
    input  logic [15:0] src3,
    input  logic [15:0] vol,
    output logic [15:0] sound_out,
    output logic        sample_tick,
    output logic        sample_valid
);

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        ACC2,
        ACC3,
        CLIP
    } state_t;

    localparam logic [15:0] LAST = 16'(DIV - 1);

    state_t             state;
    logic        [15:0] cnt;
    logic signed [21:0] acc;
    logic        [15:0] snap_src [4];
    logic        [15:0] snap_vol;
    logic               snap_en;

    logic        [15:0] sel_src;
    logic        [3:0]  sel_vol;
    logic signed [20:0] src_ext;
    logic signed [20:0] vol_ext;
    logic signed [20:0] prod;
    logic signed [21:0] shifted;
    logic        [15:0] sat;

    assign sample_tick = (cnt == LAST);

    // Single shared multiplier, steered by the accumulate state.
    always_comb begin
        sel_src = '0;
        sel_vol = '0;
        unique case (state)
            ACC0: begin sel_src = snap_src[0]; sel_vol = snap_vol[3:0];   end
            ACC1: begin sel_src = snap_src[1]; sel_vol = snap_vol[7:4];   end
            ACC2: begin sel_src = snap_src[2]; sel_vol = snap_vol[11:8];  end
            ACC3: begin sel_src = snap_src[3]; sel_vol = snap_vol[15:12]; end
            default: ;
        endcase
    end

    // Gain is unsigned: zero-extend it so the product stays signed.
    assign src_ext = 21'($signed(sel_src));
    assign vol_ext = $signed({17'd0, sel_vol});
    assign prod    = src_ext * vol_ext;

    // Floor divide by 16, then clamp into the 16-bit signed range.
    always_comb begin
        shifted = acc >>> 4;
        if (shifted > 22'sd32767)
            sat = 16'h7FFF;
        else if (shifted < -22'sd32768)
            sat = 16'h8000;
        else
            sat = shifted[15:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            snap_vol     <= '0;
            snap_en      <= 1'b0;
            sound_out    <= '0;
            sample_valid <= 1'b0;
            for (int i = 0; i < 4; i++)
                snap_src[i] <= '0;
        end else begin
            cnt          <= sample_tick ? '0 : cnt + 16'd1;
            sample_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sample_tick) begin
                        snap_src[0] <= src0;
                        snap_src[1] <= src1;
                        snap_src[2] <= src2;
                        snap_src[3] <= src3;
                        snap_vol    <= vol;
                        snap_en     <= enable;
                        acc         <= '0;
                        state       <= ACC0;
                    end
                end
                ACC0: begin
                    acc   <= acc + 22'(prod);
                    state <= ACC1;
                end
                ACC1: begin
                    acc   <= acc + 22'(prod);
                    state <= ACC2;
                end
                ACC2: begin
                    acc   <= acc + 22'(prod);
                    state <= ACC3;
                end
                ACC3: begin
                    acc   <= acc + 22'(prod);
                    state <= CLIP;
                end
                CLIP: begin
                    sound_out    <= snap_en ? sat : 16'h0000;
                    sample_valid <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
